// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the hardwired control sequencer: FSM states, opcodes,
// ALU selects and the per-cycle control word produced by the decoder.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_HALT = 4'd7
    } state_e;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_NOT  = 5'b00011;
    localparam logic [4:0] OP_OR   = 5'b00100;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [3:0] ALU_NOP = 4'd0;
    localparam logic [3:0] ALU_ADD = 4'd1;
    localparam logic [3:0] ALU_SUB = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_NOT = 4'd5;

    typedef enum logic [2:0] {
        CLS_ALU3,
        CLS_NOT,
        CLS_NOP,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_e;

    // One control word per cycle; last/to_halt tell the FSM where the
    // instruction boundary falls and whether it parks in HALT.
    typedef struct packed {
        logic       pc_out;
        logic       zhi_out;
        logic       zlo_out;
        logic       mdr_out;
        logic       r_out;
        logic       mar_in;
        logic       z_in;
        logic       pc_in;
        logic       mdr_in;
        logic       ir_in;
        logic       y_in;
        logic       r_in;
        logic       inc_pc;
        logic       read;
        logic       gra;
        logic       grb;
        logic       grc;
        logic [3:0] alu_op;
        logic       illegal;
        logic       last;
        logic       to_halt;
    } ctrl_t;

    function automatic op_class_e classify(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: classify = CLS_ALU3;
            OP_NOT:                        classify = CLS_NOT;
            OP_NOP:                        classify = CLS_NOP;
            OP_HALT:                       classify = CLS_HALT;
            default:                       classify = CLS_ILLEGAL;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input logic [4:0] op);
        case (op)
            OP_ADD:  alu_of = ALU_ADD;
            OP_SUB:  alu_of = ALU_SUB;
            OP_AND:  alu_of = ALU_AND;
            OP_OR:   alu_of = ALU_OR;
            OP_NOT:  alu_of = ALU_NOT;
            default: alu_of = ALU_NOP;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational control-word decoder: maps the current step and the opcode
// held in IR to the datapath strobes and ALU select for that cycle.
module ctrl_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW = 5
) (
    input  state_e         state,
    input  logic [OPW-1:0] opcode,
    output ctrl_t          ctrl
);

    op_class_e cls;

    always_comb begin
        ctrl        = '0;
        ctrl.alu_op = ALU_NOP;
        cls         = classify(opcode);

        case (state)
            ST_T0: begin
                ctrl.pc_out = 1'b1;
                ctrl.mar_in = 1'b1;
                ctrl.inc_pc = 1'b1;
                ctrl.z_in   = 1'b1;
            end
            // Held here while memory is busy; re-asserting PCin is harmless
            // because Z still carries PC+1.
            ST_T1: begin
                ctrl.zlo_out = 1'b1;
                ctrl.pc_in   = 1'b1;
                ctrl.read    = 1'b1;
                ctrl.mdr_in  = 1'b1;
            end
            ST_T2: begin
                ctrl.mdr_out = 1'b1;
                ctrl.ir_in   = 1'b1;
            end
            ST_T3: begin
                case (cls)
                    CLS_ALU3: begin
                        ctrl.grb   = 1'b1;
                        ctrl.r_out = 1'b1;
                        ctrl.y_in  = 1'b1;
                    end
                    CLS_NOT: begin
                        ctrl.grb    = 1'b1;
                        ctrl.r_out  = 1'b1;
                        ctrl.z_in   = 1'b1;
                        ctrl.alu_op = ALU_NOT;
                    end
                    CLS_NOP: begin
                        ctrl.last = 1'b1;
                    end
                    CLS_HALT: begin
                        ctrl.last    = 1'b1;
                        ctrl.to_halt = 1'b1;
                    end
                    default: begin
                        ctrl.illegal = 1'b1;
                        ctrl.last    = 1'b1;
                    end
                endcase
            end
            ST_T4: begin
                if (cls == CLS_NOT) begin
                    ctrl.zlo_out = 1'b1;
                    ctrl.gra     = 1'b1;
                    ctrl.r_in    = 1'b1;
                    ctrl.last    = 1'b1;
                end else begin
                    ctrl.grc    = 1'b1;
                    ctrl.r_out  = 1'b1;
                    ctrl.z_in   = 1'b1;
                    ctrl.alu_op = alu_of(opcode);
                end
            end
            ST_T5: begin
                ctrl.zlo_out = 1'b1;
                ctrl.gra     = 1'b1;
                ctrl.r_in    = 1'b1;
                ctrl.last    = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit sequencing the datapath through fetch and
// execute steps, with run/halt handshake and a retired-instruction counter.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW   = 5,
    parameter int CNT_W = 16
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             Start,
    input  logic             Stop,
    input  logic             MemReady,
    input  logic [31:0]      IR,
    output logic             PCout,
    output logic             Zhiout,
    output logic             Zlowout,
    output logic             MDRout,
    output logic             Rout,
    output logic             MARin,
    output logic             Zin,
    output logic             PCin,
    output logic             MDRin,
    output logic             IRin,
    output logic             Yin,
    output logic             Rin,
    output logic             IncPC,
    output logic             Read,
    output logic             Gra,
    output logic             Grb,
    output logic             Grc,
    output logic [3:0]       AluOp,
    output logic             Running,
    output logic             Halted,
    output logic             Illegal,
    output logic [CNT_W-1:0] Retired
);

    state_e             state_q, state_d;
    logic               stop_pending_q, stop_pending_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    ctrl_t              ctrl;
    logic [OPW-1:0]     opcode;
    logic               unused_ir_bits;

    assign opcode         = IR[31 -: OPW];
    assign unused_ir_bits = ^IR[31-OPW:0];

    ctrl_decode #(
        .OPW (OPW)
    ) u_decode (
        .state  (state_q),
        .opcode (opcode),
        .ctrl   (ctrl)
    );

    always_comb begin
        state_d        = state_q;
        stop_pending_d = stop_pending_q;
        retired_d      = retired_q;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (Start) begin
                    state_d        = ST_T0;
                    stop_pending_d = 1'b0;
                end
            end
            default: begin
                if (ctrl.last) begin
                    retired_d      = retired_q + CNT_W'(1);
                    stop_pending_d = 1'b0;
                    if (ctrl.to_halt || Stop || stop_pending_q) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_T0;
                    end
                end else begin
                    stop_pending_d = stop_pending_q | Stop;
                    case (state_q)
                        ST_T0:   state_d = ST_T1;
                        ST_T1:   state_d = MemReady ? ST_T2 : ST_T1;
                        ST_T2:   state_d = ST_T3;
                        ST_T3:   state_d = ST_T4;
                        ST_T4:   state_d = ST_T5;
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_q        <= ST_IDLE;
            stop_pending_q <= 1'b0;
            retired_q      <= '0;
        end else begin
            state_q        <= state_d;
            stop_pending_q <= stop_pending_d;
            retired_q      <= retired_d;
        end
    end

    assign PCout   = ctrl.pc_out;
    assign Zhiout  = ctrl.zhi_out;
    assign Zlowout = ctrl.zlo_out;
    assign MDRout  = ctrl.mdr_out;
    assign Rout    = ctrl.r_out;
    assign MARin   = ctrl.mar_in;
    assign Zin     = ctrl.z_in;
    assign PCin    = ctrl.pc_in;
    assign MDRin   = ctrl.mdr_in;
    assign IRin    = ctrl.ir_in;
    assign Yin     = ctrl.y_in;
    assign Rin     = ctrl.r_in;
    assign IncPC   = ctrl.inc_pc;
    assign Read    = ctrl.read;
    assign Gra     = ctrl.gra;
    assign Grb     = ctrl.grb;
    assign Grc     = ctrl.grc;
    assign AluOp   = ctrl.alu_op;
    assign Illegal = ctrl.illegal;
    assign Running = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign Halted  = (state_q == ST_HALT);
    assign Retired = retired_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed scenarios then randomized traffic,
// all checked cycle by cycle against a micro-step queue model.
module tb_control_sequencer;
    import cpu_ctrl_pkg::*;

    logic        Clock = 1'b0;
    logic        Clear, Start, Stop, MemReady;
    logic [31:0] IR;

    logic PCout, Zhiout, Zlowout, MDRout, Rout, MARin, Zin, PCin, MDRin, IRin;
    logic Yin, Rin, IncPC, Read, Gra, Grb, Grc, Running, Halted, Illegal;
    logic [3:0]  AluOp;
    logic [15:0] Retired;
    logic [21:0] unused_w;
    logic [3:0]  unused_alu_w;
    logic [3:0]  retired_w;

    always #5 Clock = ~Clock;

    control_sequencer #(.OPW(5), .CNT_W(16)) dut (
        .Clock(Clock), .Clear(Clear), .Start(Start), .Stop(Stop),
        .MemReady(MemReady), .IR(IR),
        .PCout(PCout), .Zhiout(Zhiout), .Zlowout(Zlowout), .MDRout(MDRout),
        .Rout(Rout), .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin),
        .IRin(IRin), .Yin(Yin), .Rin(Rin), .IncPC(IncPC), .Read(Read),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .AluOp(AluOp), .Running(Running),
        .Halted(Halted), .Illegal(Illegal), .Retired(Retired)
    );

    // Narrow-counter instance so wrap-around is reached within a short run.
    control_sequencer #(.OPW(5), .CNT_W(4)) dut_w (
        .Clock(Clock), .Clear(Clear), .Start(Start), .Stop(Stop),
        .MemReady(MemReady), .IR(IR),
        .PCout(unused_w[0]), .Zhiout(unused_w[1]), .Zlowout(unused_w[2]),
        .MDRout(unused_w[3]), .Rout(unused_w[4]), .MARin(unused_w[5]),
        .Zin(unused_w[6]), .PCin(unused_w[7]), .MDRin(unused_w[8]),
        .IRin(unused_w[9]), .Yin(unused_w[10]), .Rin(unused_w[11]),
        .IncPC(unused_w[12]), .Read(unused_w[13]), .Gra(unused_w[14]),
        .Grb(unused_w[15]), .Grc(unused_w[16]), .AluOp(unused_alu_w),
        .Running(unused_w[17]), .Halted(unused_w[18]), .Illegal(unused_w[19]),
        .Retired(retired_w)
    );
    assign unused_w[21:20] = 2'b00;

    localparam logic [16:0] B_PCOUT = 17'h1 << 0;
    localparam logic [16:0] B_ZHI   = 17'h1 << 1;
    localparam logic [16:0] B_ZLO   = 17'h1 << 2;
    localparam logic [16:0] B_MDROUT= 17'h1 << 3;
    localparam logic [16:0] B_ROUT  = 17'h1 << 4;
    localparam logic [16:0] B_MARIN = 17'h1 << 5;
    localparam logic [16:0] B_ZIN   = 17'h1 << 6;
    localparam logic [16:0] B_PCIN  = 17'h1 << 7;
    localparam logic [16:0] B_MDRIN = 17'h1 << 8;
    localparam logic [16:0] B_IRIN  = 17'h1 << 9;
    localparam logic [16:0] B_YIN   = 17'h1 << 10;
    localparam logic [16:0] B_RIN   = 17'h1 << 11;
    localparam logic [16:0] B_INCPC = 17'h1 << 12;
    localparam logic [16:0] B_READ  = 17'h1 << 13;
    localparam logic [16:0] B_GRA   = 17'h1 << 14;
    localparam logic [16:0] B_GRB   = 17'h1 << 15;
    localparam logic [16:0] B_GRC   = 17'h1 << 16;

    logic [16:0] obs_strb;
    assign obs_strb = {Grc, Grb, Gra, Read, IncPC, Rin, Yin, IRin, MDRin, PCin,
                       Zin, MARin, Rout, MDRout, Zlowout, Zhiout, PCout};

    typedef struct packed {
        logic [16:0] strb;
        logic [3:0]  alu;
        logic        ill;
        logic        last;
        logic        halt;
        logic        wmem;
    } step_t;

    step_t       q[$];
    int          mode;          // 0 idle, 1 running, 2 halted
    int unsigned retired;
    bit          stop_pend;
    bit          rand_ir_en;
    logic [31:0] next_ir, model_ir;
    int          checks = 0;
    int          errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic step_t mk(input logic [16:0] s, input logic [3:0] a,
                                 input bit ill, input bit last, input bit halt, input bit wm);
        step_t r;
        r.strb = s; r.alu = a; r.ill = ill; r.last = last; r.halt = halt; r.wmem = wm;
        return r;
    endfunction

    function automatic logic [3:0] exp_alu(input logic [4:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            default: return ALU_OR;
        endcase
    endfunction

    function automatic logic [31:0] rand_ir();
        logic [4:0] op;
        int r;
        r = $urandom_range(0, 15);
        case (r)
            0, 1, 2: op = OP_ADD;
            3:       op = OP_SUB;
            4:       op = OP_AND;
            5:       op = OP_OR;
            6, 7:    op = OP_NOT;
            8, 9:    op = OP_NOP;
            10:      op = OP_HALT;
            default: op = 5'($urandom);
        endcase
        return {op, 27'($urandom)};
    endfunction

    function automatic void load_instr(input logic [31:0] ir);
        logic [4:0] op;
        op = ir[31:27];
        q.push_back(mk(B_PCOUT | B_MARIN | B_INCPC | B_ZIN, ALU_NOP, 0, 0, 0, 0));
        q.push_back(mk(B_ZLO | B_PCIN | B_READ | B_MDRIN, ALU_NOP, 0, 0, 0, 1));
        q.push_back(mk(B_MDROUT | B_IRIN, ALU_NOP, 0, 0, 0, 0));
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                q.push_back(mk(B_GRB | B_ROUT | B_YIN, ALU_NOP, 0, 0, 0, 0));
                q.push_back(mk(B_GRC | B_ROUT | B_ZIN, exp_alu(op), 0, 0, 0, 0));
                q.push_back(mk(B_ZLO | B_GRA | B_RIN, ALU_NOP, 0, 1, 0, 0));
            end
            OP_NOT: begin
                q.push_back(mk(B_GRB | B_ROUT | B_ZIN, ALU_NOT, 0, 0, 0, 0));
                q.push_back(mk(B_ZLO | B_GRA | B_RIN, ALU_NOP, 0, 1, 0, 0));
            end
            OP_NOP:  q.push_back(mk(17'h0, ALU_NOP, 0, 1, 0, 0));
            OP_HALT: q.push_back(mk(17'h0, ALU_NOP, 0, 1, 1, 0));
            default: q.push_back(mk(17'h0, ALU_NOP, 1, 1, 0, 0));
        endcase
    endfunction

    function automatic void begin_instr();
        model_ir = next_ir;
        load_instr(model_ir);
        if (rand_ir_en) next_ir = rand_ir();
    endfunction

    // Advances the model by one clock using the inputs about to be sampled.
    function automatic void model_step();
        step_t s;
        if (Clear) begin
            mode = 0; q.delete(); retired = 0; stop_pend = 0;
        end else if (mode != 1) begin
            if (Start) begin
                mode = 1; stop_pend = 0; begin_instr();
            end
        end else begin
            s = q[0];
            if (s.wmem && !MemReady) begin
                if (Stop) stop_pend = 1;
            end else begin
                void'(q.pop_front());
                if (s.last) begin
                    retired++;
                    if (s.halt || Stop || stop_pend) mode = 2;
                    else begin_instr();
                    stop_pend = 0;
                end else if (Stop) begin
                    stop_pend = 1;
                end
            end
        end
    endfunction

    task automatic check_outputs();
        step_t s;
        s = '0;
        s.alu = ALU_NOP;
        if (mode == 1) s = q[0];
        check_val("strobes", 32'(obs_strb), 32'(s.strb));
        check_val("aluop",   32'(AluOp),    32'(s.alu));
        check_val("illegal", 32'(Illegal),  32'(s.ill));
        check_val("running", 32'(Running),  32'(mode == 1));
        check_val("halted",  32'(Halted),   32'(mode == 2));
        check_val("retired", 32'(Retired),  retired & 32'hFFFF);
        check_val("retired_wrap4", 32'(retired_w), retired & 32'hF);
    endtask

    task automatic cycle(input bit clr, input bit st, input bit sp, input bit mr);
        Clear = clr; Start = st; Stop = sp; MemReady = mr;
        model_step();
        @(posedge Clock);
        #1;
        IR = model_ir;
        @(negedge Clock);
        check_outputs();
    endtask

    initial begin
        Clear = 1'b1; Start = 1'b0; Stop = 1'b0; MemReady = 1'b1;
        IR = 32'h0; model_ir = 32'h0; next_ir = 32'h0;
        mode = 0; retired = 0; stop_pend = 0; rand_ir_en = 0;
        @(negedge Clock);

        cycle(1, 0, 0, 1);
        cycle(1, 1, 1, 1);

        // NOT R5,R2 with memory always ready
        next_ir = 32'h1A920000;
        cycle(0, 1, 0, 1);
        next_ir = 32'h01128000;                 // ADD follows
        repeat (5) cycle(0, 0, 0, 1);

        // ADD with three wait cycles in T1
        next_ir = 32'h08432000;                 // SUB follows
        cycle(0, 0, 0, 0);
        repeat (3) cycle(0, 0, 0, 0);
        repeat (5) cycle(0, 0, 0, 1);

        // SUB with Stop pulsed in T2, then halt and restart
        cycle(0, 0, 0, 1);
        cycle(0, 0, 1, 1);
        repeat (4) cycle(0, 0, 0, 1);
        cycle(0, 0, 1, 1);
        next_ir = 32'hF8000000;                 // unknown opcode 11111
        cycle(0, 1, 1, 1);

        // illegal opcode, then an ADD cleared mid-execute
        next_ir = 32'h00000000;
        repeat (3) cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        repeat (4) cycle(0, 0, 0, 1);
        cycle(1, 0, 0, 1);
        cycle(0, 0, 0, 1);

        // HALT opcode
        next_ir = 32'hD8000000;
        cycle(0, 1, 0, 1);
        repeat (6) cycle(0, 0, 0, 1);

        // NOP stream to push the narrow counter through wrap
        next_ir = {OP_NOP, 27'h0};
        cycle(0, 1, 0, 1);
        repeat (80) cycle(0, 0, 0, 1);

        rand_ir_en = 1;
        next_ir = rand_ir();
        repeat (3000) begin
            cycle($urandom_range(0, 299) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 24) == 0,
                  $urandom_range(0, 3) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit that sequences the existing Datapath through fetch (T0–T2) and execute (T3–T5) steps.
- Replaces hand-driven control strobes with a Moore FSM decoding IR.
- Sits beside Datapath; drives its register-transfer enables, ALU op select, and register-select strobes (Gra/Grb/Grc, Rin/Rout) for the select-and-encode logic.
- Provides run/halt handshake and a retired-instruction counter.

Parameters:
- OPW, 5, opcode field width (IR[31:27]).
- CNT_W, 16, width of retired-instruction counter.

Ports:
- Clock  in  1  system clock, all state on rising edge.
- Clear  in  1  synchronous, active-high reset.
- Start  in  1  leave IDLE/HALT and begin fetch at next edge.
- Stop  in  1  request halt; honoured at next instruction boundary.
- MemReady  in  1  memory read data valid; gates T1.
- IR  in  32  instruction register contents (opcode IR[31:27]).
- PCout, Zhiout, Zlowout, MDRout, Rout  out  1 each  bus-drive strobes.
- MARin, Zin, PCin, MDRin, IRin, Yin, Rin  out  1 each  register load strobes.
- IncPC, Read  out  1 each  PC increment, memory read.
- Gra, Grb, Grc  out  1 each  register field select for encode logic.
- AluOp  out  4  ALU function select (package constants).
- Running  out  1  high in T0–T5.
- Halted  out  1  high in HALT state.
- Illegal  out  1  one-cycle pulse on unknown opcode.
- Retired  out  CNT_W  count of completed instructions.

Behaviour:
- States: IDLE, T0, T1, T2, T3, T4, T5, HALT. Moore outputs, decoded from the registered state plus IR opcode (T3–T5 only).
- Clear (sync, high): state=IDLE, Retired=0, stop_pending=0, all strobes 0, AluOp=ALU_NOP. Clear overrides Start/Stop and mid-instruction state; the instruction in flight is abandoned and not counted.
- IDLE/HALT: all strobes 0. Start=1 → T0 next edge. Start ignored in any other state.
- T0: PCout, MARin, IncPC, Zin → T1.
- T1: Zlowout, PCin, Read, MDRin. If MemReady=0, hold T1 with the same strobes. PCin may re-assert while held; the datapath tolerates this because Z holds PC+1. MemReady=1 → T2.
- T2: MDRout, IRin → T3.
- T3 decode, IR latched by end of T2:
  - ADD/SUB/AND/OR: Grb, Rout, Yin → T4.
  - NOT: Grb, Rout, Zin, AluOp=ALU_NOT → T4.
  - NOP: no strobes → boundary.
  - HALT: no strobes → HALT; Retired increments.
  - Other opcode: treated as NOP; Illegal=1 for this cycle.
- T4:
  - 3-register ops: Grc, Rout, Zin, AluOp=op → T5.
  - NOT: Zlowout, Gra, Rin → boundary.
- T5: Zlowout, Gra, Rin → boundary.
- Boundary (last execute cycle): Retired += 1 (wraps modulo 2^CNT_W). Next state is HALT if Stop=1 or stop_pending=1, else T0. stop_pending is then cleared.
- Stop asserted in T0–T5 sets stop_pending. Stop in IDLE/HALT has no effect.
- Stop and Start both high in HALT: Start wins → T0, stop_pending=0.
- AluOp=ALU_NOP whenever not in an ALU step.
- Zhiout is never asserted by the ops in scope; it stays 0.

Decomposition:
- Package cpu_ctrl_pkg: state encoding (4-bit), opcode constants OP_ADD=5'b00000, OP_SUB=5'b00001, OP_AND=5'b00010, OP_NOT=5'b00011, OP_OR=5'b00100, OP_NOP=5'b11010, OP_HALT=5'b11011; AluOp constants ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOT.
- One sub-module, ctrl_decode: combinational (state, opcode) → strobe vector.
- FSM, stop_pending and counter stay in control_sequencer.

Test Plan:
- Clear, then Start pulse, IR=32'h1A920000 (NOT R5,R2), MemReady=1 → states T0,T1,T2,T3,T4 then T0. T3: Grb, Rout, Zin, AluOp=ALU_NOT. T4: Zlowout, Gra, Rin. Retired=1.
- ADD (IR[31:27]=00000), MemReady low for 3 cycles in T1 → T1 held 4 cycles with Read/MDRin steady. T3 Yin, T4 Zin with AluOp=ALU_ADD, T5 Rin. Retired increments once.
- Stop pulse during T2 of a SUB → instruction completes through T5, then HALT, Halted=1. Start → T0.
- IR opcode 11111 → Illegal high exactly one cycle in T3, no Rin/Zin, returns to T0, Retired increments.
- Clear asserted in T4 of an ADD → next edge IDLE, all strobes 0, Retired=0. HALT opcode → HALT with Retired incremented.
- Retired preset to 16'hFFFF via 65535 NOPs (or forced), one more NOP → Retired=16'h0000.
